// File: rtl/mgmt_pkg.sv
// Shared types and widths for the management bus arbiter.
package mgmt_pkg;

    localparam int unsigned MGMT_ADDR_W = 16;
    localparam int unsigned MGMT_DATA_W = 8;
    localparam int unsigned NUM_MASTERS = 2;

    // One buffered management operation.
    typedef struct packed {
        logic                   is_rd;
        logic [MGMT_ADDR_W-1:0] addr;
        logic [MGMT_DATA_W-1:0] data;
    } mgmt_op_t;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mgmt_req_slot.sv
// Single-entry request buffer for one master: capture, drop detection and sticky error.
// The slot stores operations in the package op format, so ADDR_WIDTH and DATA_WIDTH
// are expected to match MGMT_ADDR_W and MGMT_DATA_W.
module mgmt_req_slot
    import mgmt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MGMT_ADDR_W,
    parameter int unsigned DATA_WIDTH = MGMT_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  free,
    input  logic                  err_set,
    input  logic                  err_clr,
    output logic                  ready,
    output logic                  err,
    output mgmt_op_t              op
);

    logic any_req;
    logic accept;
    logic drop;

    // Exactly one strobe into an empty slot is accepted; anything else is a drop.
    always_comb begin
        any_req = rd_en | wr_en;
        accept  = ready & (rd_en ^ wr_en);
        drop    = (rd_en & wr_en) | (any_req & ~ready);
    end

    // Slot occupancy, payload capture and sticky error (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b1;
            err   <= 1'b0;
            op    <= '0;
        end else begin
            if (accept) begin
                ready    <= 1'b0;
                op.is_rd <= rd_en;
                op.addr  <= MGMT_ADDR_W'(addr);
                op.data  <= wr_en ? MGMT_DATA_W'(wr_data) : '0;
            end else if (free) begin
                ready <= 1'b1;
            end
            if (drop || err_set) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mgmt_bus_arbiter.sv
// Round-robin arbiter sharing the management register bus between two masters.
module mgmt_bus_arbiter
    import mgmt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MGMT_ADDR_W,
    parameter int unsigned DATA_WIDTH = MGMT_DATA_W,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_MASTERS-1:0]               s_rd_en,
    input  logic [NUM_MASTERS-1:0]               s_wr_en,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_wr_data,
    output logic [NUM_MASTERS-1:0]               s_ready,
    output logic [NUM_MASTERS-1:0]               s_rd_valid,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_rd_data,
    output logic [NUM_MASTERS-1:0]               s_wr_done,
    output logic [NUM_MASTERS-1:0]               s_err,
    input  logic [NUM_MASTERS-1:0]               s_err_clr,
    output logic                                 m_rd_en,
    output logic [ADDR_WIDTH-1:0]                m_rd_addr,
    input  logic                                 m_rd_valid,
    input  logic [DATA_WIDTH-1:0]                m_rd_data,
    output logic                                 m_wr_en,
    output logic [ADDR_WIDTH-1:0]                m_wr_addr,
    output logic [DATA_WIDTH-1:0]                m_wr_data
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    mgmt_op_t          slot_op [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] slot_full;
    logic [NUM_MASTERS-1:0] slot_free;
    logic [NUM_MASTERS-1:0] slot_err_set;

    logic                  m_rd_en_d;
    logic [ADDR_WIDTH-1:0] m_rd_addr_d;
    logic                  m_wr_en_d;
    logic [ADDR_WIDTH-1:0] m_wr_addr_d;
    logic [DATA_WIDTH-1:0] m_wr_data_d;
    logic [NUM_MASTERS-1:0] s_rd_valid_d;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_rd_data_d;
    logic [NUM_MASTERS-1:0] s_wr_done_d;

    logic     pick;
    mgmt_op_t pick_op;

    // One request buffer per master.
    for (genvar i = 0; i < int'(NUM_MASTERS); i++) begin : g_slot
        mgmt_req_slot #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd_en   (s_rd_en[i]),
            .wr_en   (s_wr_en[i]),
            .addr    (s_addr[i]),
            .wr_data (s_wr_data[i]),
            .free    (slot_free[i]),
            .err_set (slot_err_set[i]),
            .err_clr (s_err_clr[i]),
            .ready   (s_ready[i]),
            .err     (s_err[i]),
            .op      (slot_op[i])
        );
    end

    assign slot_full = ~s_ready;

    // Next-state, grant selection, timeout and bus drive decisions.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        m_rd_en_d    = 1'b0;
        m_rd_addr_d  = m_rd_addr;
        m_wr_en_d    = 1'b0;
        m_wr_addr_d  = m_wr_addr;
        m_wr_data_d  = m_wr_data;
        s_rd_valid_d = '0;
        s_rd_data_d  = s_rd_data;
        s_wr_done_d  = '0;
        slot_free    = '0;
        slot_err_set = '0;

        // Round-robin: a lone full slot wins, a tie goes away from the last grant.
        pick    = (slot_full == 2'b11) ? ~last_grant_q : slot_full[1];
        pick_op = slot_op[pick];

        unique case (state_q)
            IDLE: begin
                if (|slot_full) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    if (pick_op.is_rd) begin
                        m_rd_en_d   = 1'b1;
                        m_rd_addr_d = ADDR_WIDTH'(pick_op.addr);
                        timer_d     = '0;
                        state_d     = RD_WAIT;
                    end else begin
                        m_wr_en_d          = 1'b1;
                        m_wr_addr_d        = ADDR_WIDTH'(pick_op.addr);
                        m_wr_data_d        = DATA_WIDTH'(pick_op.data);
                        s_wr_done_d[pick]  = 1'b1;
                        slot_free[pick]    = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (m_rd_valid) begin
                    s_rd_valid_d[grant_q] = 1'b1;
                    s_rd_data_d[grant_q]  = m_rd_data;
                    slot_free[grant_q]    = 1'b1;
                    state_d               = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    s_rd_valid_d[grant_q] = 1'b1;
                    s_rd_data_d[grant_q]  = '0;
                    slot_err_set[grant_q] = 1'b1;
                    slot_free[grant_q]    = 1'b1;
                    state_d               = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, arbitration pointer, timer and registered bus/return outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            m_rd_en      <= 1'b0;
            m_rd_addr    <= '0;
            m_wr_en      <= 1'b0;
            m_wr_addr    <= '0;
            m_wr_data    <= '0;
            s_rd_valid   <= '0;
            s_rd_data    <= '0;
            s_wr_done    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            m_rd_en      <= m_rd_en_d;
            m_rd_addr    <= m_rd_addr_d;
            m_wr_en      <= m_wr_en_d;
            m_wr_addr    <= m_wr_addr_d;
            m_wr_data    <= m_wr_data_d;
            s_rd_valid   <= s_rd_valid_d;
            s_rd_data    <= s_rd_data_d;
            s_wr_done    <= s_wr_done_d;
        end
    end

endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// Scoreboard bench for mgmt_bus_arbiter: directed scenarios, decoupled bus/return monitor.
module tb_mgmt_bus_arbiter;
    import mgmt_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            s_rd_en = '0;
    logic [1:0]            s_wr_en = '0;
    logic [1:0][AW-1:0]    s_addr = '0;
    logic [1:0][DW-1:0]    s_wr_data = '0;
    logic [1:0]            s_ready;
    logic [1:0]            s_rd_valid;
    logic [1:0][DW-1:0]    s_rd_data;
    logic [1:0]            s_wr_done;
    logic [1:0]            s_err;
    logic [1:0]            s_err_clr = '0;
    logic                  m_rd_en;
    logic [AW-1:0]         m_rd_addr;
    logic                  m_rd_valid = 1'b0;
    logic [DW-1:0]         m_rd_data = '0;
    logic                  m_wr_en;
    logic [AW-1:0]         m_wr_addr;
    logic [DW-1:0]         m_wr_data;

    always #5 clk = ~clk;

    mgmt_bus_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_rd_en    (s_rd_en),
        .s_wr_en    (s_wr_en),
        .s_addr     (s_addr),
        .s_wr_data  (s_wr_data),
        .s_ready    (s_ready),
        .s_rd_valid (s_rd_valid),
        .s_rd_data  (s_rd_data),
        .s_wr_done  (s_wr_done),
        .s_err      (s_err),
        .s_err_clr  (s_err_clr),
        .m_rd_en    (m_rd_en),
        .m_rd_addr  (m_rd_addr),
        .m_rd_valid (m_rd_valid),
        .m_rd_data  (m_rd_data),
        .m_wr_en    (m_wr_en),
        .m_wr_addr  (m_wr_addr),
        .m_wr_data  (m_wr_data)
    );

    typedef struct {
        logic          is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gap;
    } bus_exp_t;

    typedef struct {
        int            m;
        logic [DW-1:0] data;
        int            lat;
    } ret_exp_t;

    bus_exp_t exp_bus[$];
    ret_exp_t exp_ret[$];
    int       wdone_cnt [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_en  = 0;
    int last_bus_cyc = 0;
    logic          outst = 1'b0;
    logic [AW-1:0] held  = '0;

    int            rsp_lat  = -1;
    logic [DW-1:0] rsp_data = '0;
    logic          rsp_echo = 1'b0;
    int            rsp_cnt  = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream register interface model: answers rsp_lat cycles after m_rd_en.
    always @(negedge clk) begin
        if (m_rd_en) rsp_cnt = rsp_lat;
        if (rsp_cnt == 0) begin
            m_rd_valid = 1'b1;
            m_rd_data  = rsp_echo ? m_rd_addr[DW-1:0] : rsp_data;
            rsp_cnt    = -1;
        end else begin
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
            if (rsp_cnt > 0) rsp_cnt = rsp_cnt - 1;
        end
    end

    // Monitor: pops expected bus ops and read returns as the DUT presents them.
    always @(negedge clk) begin
        bus_exp_t e;
        ret_exp_t r;
        if (rst_n) begin
            if (m_wr_en || m_rd_en) begin
                if (exp_bus.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bus_unexpected: rd=%0b wr=%0b rd_addr=%0h wr_addr=%0h expected no op", m_rd_en, m_wr_en, m_rd_addr, m_wr_addr);
                end else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind", 32'(m_rd_en), 32'(e.is_rd));
                    if (e.is_rd) begin
                        chk("rd_addr", 32'(m_rd_addr), 32'(e.addr));
                        t_en  = cyc;
                        outst = 1'b1;
                        held  = m_rd_addr;
                    end else begin
                        chk("wr_addr", 32'(m_wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(m_wr_data), 32'(e.data));
                    end
                    if (e.gap >= 0) chk("bus_gap", 32'(cyc - last_bus_cyc), 32'(e.gap));
                    last_bus_cyc = cyc;
                end
            end else if (outst) begin
                chk("rd_addr_hold", 32'(m_rd_addr), 32'(held));
            end
            for (int i = 0; i < 2; i++) begin
                if (s_rd_valid[i]) begin
                    if (exp_ret.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ret_unexpected: master %0d data %0h expected no return", i, s_rd_data[i]);
                    end else begin
                        r = exp_ret.pop_front();
                        chk("ret_master", 32'(i), 32'(r.m));
                        chk("ret_data", 32'(s_rd_data[i]), 32'(r.data));
                        chk("ret_lat", 32'(cyc - t_en), 32'(r.lat));
                    end
                    outst = 1'b0;
                end
                if (s_wr_done[i]) begin
                    chk("wdone_expected", 32'(wdone_cnt[i] > 0), 32'(1));
                    chk("wdone_with_wr", 32'(m_wr_en), 32'(1));
                    if (wdone_cnt[i] > 0) wdone_cnt[i] = wdone_cnt[i] - 1;
                end
            end
        end
    end

    // Drive one request for one cycle; caller is at a falling edge.
    task automatic req(input int m, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_rd_en[m]   = rd;
        s_wr_en[m]   = wr;
        s_addr[m]    = a;
        s_wr_data[m] = d;
        @(negedge clk);
        s_rd_en[m] = 1'b0;
        s_wr_en[m] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        chk({name, "_bus_left"}, 32'(exp_bus.size()), 32'(0));
        chk({name, "_ret_left"}, 32'(exp_ret.size()), 32'(0));
        chk({name, "_wdone_left"}, 32'(wdone_cnt[0] + wdone_cnt[1]), 32'(0));
    endtask

    // Master that re-requests a read every time its slot frees up.
    task automatic master_loop(input int m);
        for (int k = 0; k < 50; k++) begin
            int w;
            w = 0;
            while (!s_ready[m] && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                chk("fair_ready_wait", 32'(s_ready[m]), 32'(1));
                break;
            end
            req(m, 1'b1, 1'b0, AW'((m + 1) * 256 + k), '0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        wdone_cnt[0] = 0;
        wdone_cnt[1] = 0;

        // Reset state
        idle(3);
        chk("rst_ready", 32'(s_ready), 32'(2'b11));
        chk("rst_err", 32'(s_err), 32'(0));
        chk("rst_rd_en", 32'(m_rd_en), 32'(0));
        chk("rst_wr_en", 32'(m_wr_en), 32'(0));
        chk("rst_rd_addr", 32'(m_rd_addr), 32'(0));
        chk("rst_rd_valid", 32'(s_rd_valid), 32'(0));
        chk("rst_wr_done", 32'(s_wr_done), 32'(0));
        #2 rst_n = 1'b1;
        idle(2);

        // Tie: both write together, master 0 first, master 1 the next cycle
        exp_bus.push_back('{1'b0, 16'h0048, 8'hAA, -1});
        exp_bus.push_back('{1'b0, 16'h0049, 8'h55, 1});
        wdone_cnt[0] = 1;
        wdone_cnt[1] = 1;
        s_wr_en      = 2'b11;
        s_addr[0]    = 16'h0048;
        s_wr_data[0] = 8'hAA;
        s_addr[1]    = 16'h0049;
        s_wr_data[1] = 8'h55;
        @(negedge clk);
        s_wr_en = 2'b00;
        idle(6);
        drain("tie");

        // Single read with 3-cycle downstream latency
        rsp_lat  = 3;
        rsp_data = 8'h01;
        exp_bus.push_back('{1'b1, 16'h0060, 8'h00, -1});
        exp_ret.push_back('{0, 8'h01, 4});
        req(0, 1'b1, 1'b0, 16'h0060, '0);
        idle(10);
        drain("single_rd");

        // Overrun: write while slot busy is dropped, read still completes
        rsp_lat  = 4;
        rsp_data = 8'h3C;
        exp_bus.push_back('{1'b1, 16'h0070, 8'h00, -1});
        exp_ret.push_back('{0, 8'h3C, 5});
        req(0, 1'b1, 1'b0, 16'h0070, '0);
        req(0, 1'b0, 1'b1, 16'h0071, 8'h99);
        idle(12);
        drain("overrun");
        chk("overrun_err0", 32'(s_err[0]), 32'(1));
        chk("overrun_err1", 32'(s_err[1]), 32'(0));
        s_err_clr[0] = 1'b1;
        @(negedge clk);
        s_err_clr[0] = 1'b0;
        chk("overrun_clr", 32'(s_err[0]), 32'(0));

        // Timeout: no response ever, zero data after TIMEOUT+1 cycles
        rsp_lat = -1;
        exp_bus.push_back('{1'b1, 16'h0080, 8'h00, -1});
        exp_ret.push_back('{1, 8'h00, 16});
        req(1, 1'b1, 1'b0, 16'h0080, '0);
        idle(25);
        drain("timeout");
        chk("timeout_err1", 32'(s_err[1]), 32'(1));
        s_err_clr[1] = 1'b1;
        s_rd_en[1]   = 1'b1;
        s_wr_en[1]   = 1'b1;
        @(negedge clk);
        s_err_clr[1] = 1'b0;
        s_rd_en[1]   = 1'b0;
        s_wr_en[1]   = 1'b0;
        chk("err_beats_clr", 32'(s_err[1]), 32'(1));
        s_err_clr[1] = 1'b1;
        @(negedge clk);
        s_err_clr[1] = 1'b0;
        chk("timeout_clr", 32'(s_err[1]), 32'(0));
        idle(3);
        drain("err_prio");

        // Fairness: continuous reads from both masters alternate 0,1,0,1
        rsp_lat  = 2;
        rsp_echo = 1'b1;
        for (int k = 0; k < 50; k++) begin
            exp_bus.push_back('{1'b1, AW'(256 + k), 8'h00, -1});
            exp_ret.push_back('{0, DW'(k), 3});
            exp_bus.push_back('{1'b1, AW'(512 + k), 8'h00, -1});
            exp_ret.push_back('{1, DW'(k), 3});
        end
        fork
            master_loop(0);
            master_loop(1);
        join
        idle(10);
        drain("fair");
        chk("fair_err", 32'(s_err), 32'(0));
        rsp_echo = 1'b0;

        // Reset during RD_WAIT clears everything at once
        rsp_lat = -1;
        exp_bus.push_back('{1'b1, 16'h0090, 8'h00, -1});
        req(0, 1'b1, 1'b0, 16'h0090, '0);
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(s_ready), 32'(2'b11));
        chk("mid_rst_rd_en", 32'(m_rd_en), 32'(0));
        chk("mid_rst_rd_addr", 32'(m_rd_addr), 32'(0));
        chk("mid_rst_rd_valid", 32'(s_rd_valid), 32'(0));
        chk("mid_rst_err", 32'(s_err), 32'(0));
        outst = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        exp_bus.push_back('{1'b0, 16'h00A0, 8'h42, -1});
        wdone_cnt[0] = 1;
        req(0, 1'b0, 1'b1, 16'h00A0, 8'h42);
        idle(6);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
